// File: rtl/stream_accumulator_32bits.sv
// rtl/stream_accumulator_32bits.sv - valid/ready batch accumulator around a 32-bit carry-select adder
// Define ACCUM_SATURATE_EN to clamp the accumulator at all-ones on adder carry-out.

module csel_adder_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);
    localparam int BLK  = 4;
    localparam int NBLK = 8;

    logic [BLK:0] sum0 [NBLK];
    logic [BLK:0] sum1 [NBLK];
    logic         carry;

    // Each nibble precomputes its result for both possible carry-ins.
    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        assign sum0[g] = {1'b0, A[g*BLK +: BLK]} + {1'b0, B[g*BLK +: BLK]};
        assign sum1[g] = {1'b0, A[g*BLK +: BLK]} + {1'b0, B[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    end

    always_comb begin
        carry = Cin;
        S     = '0;
        for (int g = 0; g < NBLK; g++) begin
            S[g*BLK +: BLK] = carry ? sum1[g][BLK-1:0] : sum0[g][BLK-1:0];
            carry           = carry ? sum1[g][BLK]     : sum0[g][BLK];
        end
        Cout = carry;
    end
endmodule

module stream_accumulator_32bits #(
    parameter int WIDTH     = 32,
    parameter int N_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [15:0]      out_count
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam logic [15:0] LAST = 16'(N_SAMPLES - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   acc, acc_next;
    logic [15:0]        cnt, cnt_next;
    logic               flag, flag_next;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   acc_update;

    csel_adder_32 u_adder (
        .A    (acc),
        .B    (in_data),
        .Cin  (1'b0),
        .S    (add_sum),
        .Cout (add_cout)
    );

`ifdef ACCUM_SATURATE_EN
    assign acc_update = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
    assign acc_update = add_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            flag  <= flag_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        flag_next  = flag;
        case (state)
            S_IDLE: state_next = S_ACCUM;
            S_ACCUM: begin
                if (in_valid) begin
                    acc_next  = acc_update;
                    flag_next = flag | add_cout;
                    cnt_next  = cnt + 16'd1;
                    if (cnt == LAST) state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    flag_next  = 1'b0;
                    state_next = S_ACCUM;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Abort outranks both the input accept and the result handshake.
        if (clear && state != S_IDLE) begin
            acc_next   = '0;
            cnt_next   = '0;
            flag_next  = 1'b0;
            state_next = S_ACCUM;
        end
    end

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_HOLD);
    assign out_sum   = acc;
    assign out_carry = flag;
    assign out_count = cnt;
endmodule
